// File: rtl/systolic_mac_pe.sv
// Systolic array processing element: forwards north/west operands one
// stage and accumulates their products over a tile of k_len MACs.
module systolic_mac_pe #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 72,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  signed_i,
   input  logic [CNT_WIDTH-1:0]  k_len_i,
   input  logic [DATA_WIDTH-1:0] up_i,
   input  logic                  up_valid_i,
   input  logic [DATA_WIDTH-1:0] left_i,
   input  logic                  left_valid_i,
   output logic [DATA_WIDTH-1:0] down_o,
   output logic                  down_valid_o,
   output logic [DATA_WIDTH-1:0] right_o,
   output logic                  right_valid_o,
   output logic [ACC_WIDTH-1:0]  res_o,
   output logic                  res_valid_o,
   output logic                  ovf_o,
   output logic                  busy_o
);

   localparam int PW = 2 * DATA_WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   logic [0:0]            r_state;
   logic                  r_sgn;
   logic [CNT_WIDTH-1:0]  r_len;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic                  r_ovf_t;
   logic [ACC_WIDTH-1:0]  r_res;
   logic                  r_ovf;
   logic                  r_res_valid;
   logic [DATA_WIDTH-1:0] r_down;
   logic                  r_down_v;
   logic [DATA_WIDTH-1:0] r_right;
   logic                  r_right_v;

   logic                  w_fire;
   logic                  w_mode;
   logic signed [DATA_WIDTH:0] w_a;
   logic signed [DATA_WIDTH:0] w_b;
   logic signed [PW+1:0]  w_full;
   logic [ACC_WIDTH-1:0]  w_prod;
   logic [ACC_WIDTH:0]    w_sum;
   logic                  w_add_ovf;
   logic [CNT_WIDTH-1:0]  w_len_in;
   logic [CNT_WIDTH-1:0]  w_cnt_nx;
   logic                  w_done_idle;
   logic                  w_done_acc;

   assign w_fire = en_i & up_valid_i & left_valid_i;

   // Mode comes from the input when a tile starts, else from the latch.
   assign w_mode = (r_state == S_ACC) ? r_sgn : signed_i;

   // One extra bit lets a single signed multiplier cover both modes.
   assign w_a = {w_mode & up_i[DATA_WIDTH-1], up_i};
   assign w_b = {w_mode & left_i[DATA_WIDTH-1], left_i};
   assign w_full = w_a * w_b;

   // True product always fits PW bits of its own type, so
   // sign-extending the wide result gives the right extension.
   assign w_prod = ACC_WIDTH'(w_full);

   assign w_sum = {1'b0, r_acc} + {1'b0, w_prod};

   assign w_add_ovf = w_mode
      ? ((r_acc[ACC_WIDTH-1] == w_prod[ACC_WIDTH-1]) &&
         (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
      : w_sum[ACC_WIDTH];

   // A zero length is treated as a single-MAC tile.
   assign w_len_in = (k_len_i == '0) ? CNT_WIDTH'(1) : k_len_i;
   assign w_cnt_nx = r_cnt + CNT_WIDTH'(1);

   assign w_done_idle = (w_len_in == CNT_WIDTH'(1));
   assign w_done_acc  = (w_cnt_nx == r_len);

   // Systolic forwarding of operands, independent of the MAC state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_down    <= '0;
         r_down_v  <= 1'b0;
         r_right   <= '0;
         r_right_v <= 1'b0;
      end else if (en_i) begin
         r_down    <= up_i;
         r_down_v  <= up_valid_i;
         r_right   <= left_i;
         r_right_v <= left_valid_i;
      end
   end

   // Tile FSM: accumulate on fire, publish result on the last MAC.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_sgn       <= 1'b0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_ovf_t     <= 1'b0;
         r_res       <= '0;
         r_ovf       <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         if (clr_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf_t <= 1'b0;
         end else if (w_fire) begin
            case (r_state)
               S_IDLE: begin
                  r_sgn <= signed_i;
                  r_len <= w_len_in;
                  if (w_done_idle) begin
                     r_res       <= w_prod;
                     r_ovf       <= 1'b0;
                     r_res_valid <= 1'b1;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_ovf_t     <= 1'b0;
                  end else begin
                     r_acc   <= w_prod;
                     r_cnt   <= CNT_WIDTH'(1);
                     r_ovf_t <= 1'b0;
                     r_state <= S_ACC;
                  end
               end
               S_ACC: begin
                  if (w_done_acc) begin
                     r_res       <= w_sum[ACC_WIDTH-1:0];
                     r_ovf       <= r_ovf_t | w_add_ovf;
                     r_res_valid <= 1'b1;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_ovf_t     <= 1'b0;
                     r_state     <= S_IDLE;
                  end else begin
                     r_acc   <= w_sum[ACC_WIDTH-1:0];
                     r_cnt   <= w_cnt_nx;
                     r_ovf_t <= r_ovf_t | w_add_ovf;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign down_o        = r_down;
   assign down_valid_o  = r_down_v;
   assign right_o       = r_right;
   assign right_valid_o = r_right_v;
   assign res_o         = r_res;
   assign res_valid_o   = r_res_valid;
   assign ovf_o         = r_ovf;
   assign busy_o        = (r_state == S_ACC);

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: two widths (20 and 16 bit accumulators)
// share stimulus and are checked against a tile-level arithmetic model.
module tb_systolic_mac_pe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, clr, sgn, uv, lv;
   logic [15:0] klen;
   logic [7:0]  up, left;

   logic [7:0]  a_down, a_right, b_down, b_right;
   logic        a_dv, a_rv, b_dv, b_rv;
   logic [19:0] a_res;
   logic [15:0] b_res;
   logic        a_vld, a_ovf, a_busy, b_vld, b_ovf, b_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [7:0] m_down, m_right;
   bit         m_dv, m_rv, m_busy, m_vld, m_sgn;
   int         m_len;
   longint     mq[$];
   longint     ma_res, mb_res;
   bit         ma_ovf, mb_ovf;

   always #5 clk = ~clk;

   systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(16)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
      .signed_i(sgn), .k_len_i(klen),
      .up_i(up), .up_valid_i(uv), .left_i(left), .left_valid_i(lv),
      .down_o(a_down), .down_valid_o(a_dv),
      .right_o(a_right), .right_valid_o(a_rv),
      .res_o(a_res), .res_valid_o(a_vld), .ovf_o(a_ovf), .busy_o(a_busy)
   );

   systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(16)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
      .signed_i(sgn), .k_len_i(klen),
      .up_i(up), .up_valid_i(uv), .left_i(left), .left_valid_i(lv),
      .down_o(b_down), .down_valid_o(b_dv),
      .right_o(b_right), .right_valid_o(b_rv),
      .res_o(b_res), .res_valid_o(b_vld), .ovf_o(b_ovf), .busy_o(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic longint prod(bit s, int u, int l);
      longint su, sl;
      su = (s && u >= 128) ? u - 256 : u;
      sl = (s && l >= 128) ? l - 256 : l;
      return su * sl;
   endfunction

   // Sum the tile's products with wrap at w bits, flagging any add
   // that leaves the representable range.
   task automatic eval(input int w, input bit s,
                       output longint res, output bit ovf);
      longint lim, half, t;
      lim  = longint'(1) << w;
      half = lim / 2;
      t    = 0;
      ovf  = 0;
      foreach (mq[i]) begin
         if (i == 0) t = mq[i];
         else begin
            t = t + mq[i];
            if (!s && t >= lim) begin ovf = 1; t -= lim; end
            if (s && t >= half) begin ovf = 1; t -= lim; end
            if (s && t < -half) begin ovf = 1; t += lim; end
         end
      end
      res = (t < 0) ? t + lim : t;
   endtask

   task automatic m_reset();
      m_down = 0; m_right = 0; m_dv = 0; m_rv = 0;
      m_busy = 0; m_vld = 0; m_sgn = 0; m_len = 0;
      mq.delete();
      ma_res = 0; mb_res = 0; ma_ovf = 0; mb_ovf = 0;
   endtask

   task automatic m_edge();
      m_vld = 0;
      if (en) begin
         m_down = up; m_dv = uv; m_right = left; m_rv = lv;
      end
      if (clr) begin
         m_busy = 0;
         mq.delete();
      end else if (en && uv && lv) begin
         if (!m_busy) begin
            m_sgn = sgn;
            m_len = (klen == 0) ? 1 : int'(klen);
            mq.delete();
         end
         mq.push_back(prod(m_sgn, up, left));
         if (mq.size() == m_len) begin
            eval(20, m_sgn, ma_res, ma_ovf);
            eval(16, m_sgn, mb_res, mb_ovf);
            m_vld  = 1;
            m_busy = 0;
            mq.delete();
         end else m_busy = 1;
      end
   endtask

   task automatic compare_all();
      check("a_down", a_down, m_down);
      check("a_dv", a_dv, m_dv);
      check("a_right", a_right, m_right);
      check("a_rv", a_rv, m_rv);
      check("a_res", a_res, ma_res);
      check("a_ovf", a_ovf, ma_ovf);
      check("a_vld", a_vld, m_vld);
      check("a_busy", a_busy, m_busy);
      check("b_down", b_down, m_down);
      check("b_dv", b_dv, m_dv);
      check("b_right", b_right, m_right);
      check("b_rv", b_rv, m_rv);
      check("b_res", b_res, mb_res);
      check("b_ovf", b_ovf, mb_ovf);
      check("b_vld", b_vld, m_vld);
      check("b_busy", b_busy, m_busy);
   endtask

   task automatic cyc(input bit e, input bit c, input bit s, input int k,
                      input int u, input int l, input bit vu, input bit vl);
      en = e; clr = c; sgn = s; klen = 16'(k);
      up = 8'(u); left = 8'(l); uv = vu; lv = vl;
      @(posedge clk);
      m_edge();
      #1;
      compare_all();
   endtask

   initial begin
      en = 0; clr = 0; sgn = 0; klen = 0;
      up = 0; left = 0; uv = 0; lv = 0;
      rst_n = 0;
      m_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1;

      // unsigned length-3 tile, back to back
      cyc(1, 0, 0, 3, 3, 4, 1, 1);
      cyc(1, 0, 0, 3, 5, 6, 1, 1);
      cyc(1, 0, 0, 3, 255, 255, 1, 1);
      check("r031_res", a_res, 65067);
      check("r031_vld", a_vld, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("r031_vld_off", a_vld, 0);

      // signed length-2 tile with a bubble and a stall
      cyc(1, 0, 1, 2, 8'hFD, 7, 1, 1);
      check("r032_down", a_down, 8'hFD);
      cyc(1, 0, 1, 2, 11, 22, 0, 0);
      cyc(0, 0, 1, 2, 33, 44, 1, 1);
      cyc(1, 0, 1, 2, 8'h80, 8'h80, 1, 1);
      check("r032_res", a_res, 16363);

      // 16-bit accumulator overflow, then a clean tile
      cyc(1, 0, 0, 2, 255, 255, 1, 1);
      cyc(1, 0, 0, 2, 255, 255, 1, 1);
      check("r033_res", b_res, 64514);
      check("r033_ovf", b_ovf, 1);
      cyc(1, 0, 0, 2, 1, 1, 1, 1);
      cyc(1, 0, 0, 2, 1, 1, 1, 1);
      check("r033_res2", b_res, 2);
      check("r033_ovf2", b_ovf, 0);

      // abort coincident with a fire
      cyc(1, 0, 0, 4, 7, 7, 1, 1);
      cyc(1, 0, 0, 4, 7, 7, 1, 1);
      cyc(1, 1, 0, 4, 7, 7, 1, 1);
      check("r034_busy", a_busy, 0);
      check("r034_vld", a_vld, 0);
      cyc(1, 0, 0, 1, 2, 3, 1, 1);
      check("r034_res", a_res, 6);

      // asynchronous reset mid-tile
      cyc(1, 0, 0, 4, 9, 9, 1, 1);
      cyc(1, 0, 0, 4, 9, 9, 1, 1);
      #2;
      en = 0; uv = 0; lv = 0;
      rst_n = 0;
      #1;
      m_reset();
      compare_all();
      check("r035_res_async", a_res, 0);
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1;
      cyc(1, 0, 0, 2, 1, 2, 1, 1);
      cyc(1, 0, 0, 2, 3, 4, 1, 1);
      check("r035_res", a_res, 14);

      // zero length, then mid-tile length/mode changes
      cyc(1, 0, 0, 0, 9, 9, 1, 1);
      check("r036_res", a_res, 81);
      cyc(1, 0, 0, 3, 2, 2, 1, 1);
      cyc(1, 0, 1, 1, 8'hFF, 2, 1, 1);
      check("r036_busy", a_busy, 1);
      cyc(1, 0, 1, 1, 1, 1, 1, 1);
      check("r036_res2", a_res, 4 + 510 + 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 9) < 8,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 1),
             $urandom_range(0, 4),
             $urandom_range(0, 255),
             $urandom_range(0, 255),
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/systolic_mac_pe.md
SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand width of up/left data.
REQ-002 SHALL have parameter ACC_WIDTH, default 72: accumulator/result width; legal only if ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of tile-length count.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk_i  in  1  rising-edge clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 en_i  in  1  global advance enable; 0 = stall, all registers hold.
REQ-007 clr_i  in  1  synchronous tile abort.
REQ-008 signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 k_len_i  in  CNT_WIDTH  MACs per tile.
REQ-010 up_i  in  DATA_WIDTH  operand from north; up_valid_i  in  1  qualifies up_i.
REQ-011 left_i  in  DATA_WIDTH  operand from west; left_valid_i  in  1  qualifies left_i.
REQ-012 down_o  out  DATA_WIDTH  registered up_i; down_valid_o  out  1  registered up_valid_i.
REQ-013 right_o  out  DATA_WIDTH  registered left_i; right_valid_o  out  1  registered left_valid_i.
REQ-014 res_o  out  ACC_WIDTH  last completed tile result.
REQ-015 res_valid_o  out  1  one-cycle pulse per completed tile.
REQ-016 ovf_o  out  1  overflow flag of the tile in res_o.
REQ-017 busy_o  out  1  high while a tile is in progress.

Function
REQ-018 When en_i=1, down/right data and valid outputs SHALL take up/left inputs with exactly one cycle latency, independent of MAC state and clr_i; when en_i=0 they SHALL hold.
REQ-019 fire SHALL be en_i & up_valid_i & left_valid_i; only fire cycles contribute to the accumulator.
REQ-020 Product SHALL be full 2*DATA_WIDTH wide, signed or unsigned per the tile's mode, sign- or zero-extended to ACC_WIDTH.
REQ-021 FSM SHALL have states IDLE and ACC; busy_o = (state==ACC).
REQ-022 IDLE + fire: latch signed_i and k_len_i as tile mode/length (k_len_i=0 treated as 1), acc <= product, cnt <= 1, ovf clear; go ACC unless length is 1.
REQ-023 ACC + fire: acc <= acc + product, cnt <= cnt+1; signed_i and k_len_i changes mid-tile SHALL be ignored.
REQ-024 On the fire that makes cnt equal to tile length: res_o <= final sum, ovf_o <= tile overflow, res_valid_o=1 next cycle for exactly one cycle, acc/cnt cleared, state IDLE.
REQ-025 Length-1 tile SHALL complete on its single fire, returning to/staying in IDLE.
REQ-026 Accumulation SHALL wrap modulo 2^ACC_WIDTH; tile overflow SHALL be sticky: unsigned = carry out of any add, signed = two's-complement overflow of any add.
REQ-027 res_o and ovf_o SHALL hold between completions; res_valid_o SHALL be 0 otherwise, including during stalls.
REQ-028 clr_i=1 SHALL, regardless of en_i, clear acc, cnt, tile overflow and return to IDLE with no res_valid_o pulse; clr_i SHALL take priority over a simultaneous fire (that fire discarded); res_o/ovf_o unchanged.
REQ-029 ACC with no fire (bubble or stall) SHALL hold acc and cnt.

Reset
REQ-030 rst_ni=0 SHALL immediately and asynchronously force all outputs, acc, cnt, latched mode/length to 0 and state to IDLE, including mid-tile; first fire after release starts a new tile.

Verification (DATA_WIDTH=8, ACC_WIDTH=20 unless stated)
REQ-031 Unsigned k_len=3, fires (3,4),(5,6),(255,255) back-to-back -> res_o=65067, res_valid_o single pulse cycle after third fire, ovf_o=0, busy_o low after.
REQ-032 Signed k_len=2, fires (0xFD,7),(0x80,0x80) with bubble and en_i=0 cycle between -> res_o=16363 (-21+16384), down/right streams reproduce inputs delayed one advancing cycle.
REQ-033 ACC_WIDTH=16 unsigned k_len=2, (255,255) twice -> res_o=64514, ovf_o=1; next tile (1,1),(1,1) -> res_o=2, ovf_o=0.
REQ-034 k_len=4, two fires then clr_i coincident with a third fire -> no pulse, busy_o=0; new k_len=1 tile (2,3) -> res_o=6 pulse.
REQ-035 rst_ni low mid-tile after two fires -> all outputs 0 asynchronously; after release k_len=2, (1,2),(3,4) -> res_o=14.
REQ-036 k_len_i=0, single fire (9,9) -> res_o=81 pulse; k_len_i changed mid-tile -> ignored until next tile.
